// File: rtl/fir_interp_polyphase.sv
// fir_interp_polyphase: polyphase interpolating FIR. It takes one sample per input
//   handshake and emits INTERP_FACTOR outputs, one per branch, with a round-half-up
//   shift and saturation to DATA_WIDTH.
// Latency: a sample accepted in cycle c shows branch 0 in cycle c+2 and branch p in
//   cycle c+2+p. Output is registered, so there is no combinational in->out path.
// Backpressure: out_ready low holds out/out_phase/out_valid and freezes the phase
//   counter. in_ready rises only while the last branch loads, so an output stall also
//   stalls the input.
// Ports: clk, rst (synchronous, active high); in_valid/in_ready/in form the input
//   handshake; tap_coeffs is the flattened h[], with h[i] at
//   [TAP_COEFF_WIDTH*(i+1)-1 : TAP_COEFF_WIDTH*i]; out_valid/out_ready/out/out_phase
//   form the output handshake, and out_phase is the branch index of out.
module fir_interp_polyphase #(
  parameter int DATA_WIDTH      = 5,
  parameter int TAP_COEFF_WIDTH = 5,
  parameter int NUM_TAPS        = 50,
  parameter int INTERP_FACTOR   = 2,
  parameter int OUT_SHIFT       = 0,
  localparam int PHASE_WIDTH    = (INTERP_FACTOR > 1) ? $clog2(INTERP_FACTOR) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [DATA_WIDTH-1:0]        in,
  input  logic [TAP_COEFF_WIDTH*NUM_TAPS-1:0] tap_coeffs,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [DATA_WIDTH-1:0]        out,
  output logic [PHASE_WIDTH-1:0]              out_phase
);

  localparam int M         = NUM_TAPS / INTERP_FACTOR;
  localparam int ACC_WIDTH = DATA_WIDTH + TAP_COEFF_WIDTH + $clog2(M) + 1;

  typedef logic signed [ACC_WIDTH-1:0] acc_t;
  typedef enum logic {IDLE, EMIT} state_t;

  localparam acc_t SAT_MAX = acc_t'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam acc_t SAT_MIN = -SAT_MAX - acc_t'(1);
  localparam logic [PHASE_WIDTH-1:0] LAST_PHASE = PHASE_WIDTH'(INTERP_FACTOR - 1);

  state_t                       state;
  logic [PHASE_WIDTH-1:0]       p;
  logic signed [DATA_WIDTH-1:0] x [M];

  logic                              busy;
  logic                              load;
  logic                              last;
  logic                              accept;
  logic signed [TAP_COEFF_WIDTH-1:0] coef;
  acc_t                              acc;
  acc_t                              rnd;
  logic signed [DATA_WIDTH-1:0]      sat;

  assign busy     = (state == EMIT);
  assign last     = (p == LAST_PHASE);
  // A new branch loads whenever the output register is empty or draining this cycle.
  assign load     = busy && (!out_valid || out_ready);
  // Accepting while the last branch loads lets the next sample's branch 0 follow
  // immediately, so a continuous input stream gives a bubble-free output stream.
  assign in_ready = !busy || (load && last);
  assign accept   = in_valid && in_ready;

  // Branch p of the polyphase decomposition: taps h[k*L+p] against the shared delay
  // line, at full precision.
  always_comb begin
    acc  = '0;
    coef = '0;
    for (int k = 0; k < M; k++) begin
      coef = tap_coeffs[(k * INTERP_FACTOR + int'(p)) * TAP_COEFF_WIDTH +: TAP_COEFF_WIDTH];
      acc  = acc + acc_t'(coef) * acc_t'(x[k]);
    end
  end

  // Round half up: adding half an LSB before the arithmetic shift. The accumulator's
  // spare top bit absorbs the rounding constant.
  if (OUT_SHIFT > 0) begin : g_round
    assign rnd = (acc + (acc_t'(1) <<< (OUT_SHIFT - 1))) >>> OUT_SHIFT;
  end else begin : g_no_round
    assign rnd = acc;
  end

  always_comb begin
    if (rnd > SAT_MAX) begin
      sat = SAT_MAX[DATA_WIDTH-1:0];
    end else if (rnd < SAT_MIN) begin
      sat = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      sat = rnd[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      p         <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      out_phase <= '0;
      for (int k = 0; k < M; k++) begin
        x[k] <= '0;
      end
    end else begin
      // The last branch loads from the pre-shift line, because the shift lands on the
      // same edge.
      if (accept) begin
        x[0] <= in;
        for (int k = 1; k < M; k++) begin
          x[k] <= x[k-1];
        end
      end

      if (load) begin
        out       <= sat;
        out_phase <= p;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            state <= EMIT;
            p     <= '0;
          end
        end
        EMIT: begin
          if (load) begin
            if (last) begin
              p <= '0;
              if (!accept) begin
                state <= IDLE;
              end
            end else begin
              p <= p + PHASE_WIDTH'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          p     <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/fir_interp_polyphase.md
# fir_interp_polyphase

Parametrised polyphase interpolating FIR: the successor to the single-rate transposed FIR in the interpolation-filter datapath. It accepts one input sample per handshake and emits `INTERP_FACTOR` output samples, one for each polyphase branch, at up to one output per clock. It adds a valid/ready handshake on both sides, output back-pressure, a selectable rounding shift and saturation to `DATA_WIDTH`. It sits between the sample source and the DAC-side stage, using the same flattened coefficient bus as the existing FIR.

## Interface
- `DATA_WIDTH`, 5: signed input/output sample width.
- `TAP_COEFF_WIDTH`, 5: signed coefficient width.
- `NUM_TAPS`, 50: prototype filter length. Must be a multiple of `INTERP_FACTOR`.
- `INTERP_FACTOR`, 2: interpolation factor L (≥1). Each branch has M = NUM_TAPS/L taps.
- `OUT_SHIFT`, 0: arithmetic right shift applied to the accumulator, with round-half-up.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  block can accept a sample.
- `in`  in  DATA_WIDTH  signed input sample.
- `tap_coeffs`  in  TAP_COEFF_WIDTH*NUM_TAPS  flattened coefficients; h[i] occupies bits [TAP_COEFF_WIDTH*(i+1)-1 : TAP_COEFF_WIDTH*i].
- `out_valid`  out  1  output sample valid.
- `out_ready`  in  1  downstream accepts the output.
- `out`  out  DATA_WIDTH  signed output sample.
- `out_phase`  out  clog2(L) (min 1)  branch index p of the current `out`.

## Operation
- **Delay line:** x[0..M-1]. On accept (`in_valid && in_ready`): x[0]<=in, x[k]<=x[k-1].
- **Branch p output:** y_p = Σ_{k=0..M-1} h[k·L+p]·x[k].
- **Accumulator:** full precision, width DATA_WIDTH+TAP_COEFF_WIDTH+clog2(M)+1. No intermediate truncation.
- **Rounding:** if OUT_SHIFT>0, r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT; otherwise r = acc.
- **Saturation:** r is clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- **FSM states:**
  - IDLE (busy=0).
  - EMIT (busy=1, phase counter p in 0..L-1).
- **Load condition:** `load = busy && (!out_valid || out_ready)`. On load: out<=sat(r_p), out_phase<=p, out_valid<=1, then p increments.
- **Output retire:** `out_valid && out_ready && !load` clears out_valid.
- **in_ready** = !busy || (load && p==L-1). This is combinational from state and `out_ready`.
- **Transitions:**
  - IDLE→EMIT on accept, with p<=0.
  - On load with p==L-1: accept in the same cycle → stay in EMIT with p<=0 on the new delay line. No accept → IDLE.
  - The branch for p==L-1 uses the pre-shift delay line. All registers update at the same edge.
- **Coefficients:** `tap_coeffs` must be stable while busy. A change takes effect at the next computed branch.
- **Reset:**
  - out=0, out_valid=0, out_phase=0, busy=0, p=0.
  - Delay line cleared to 0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-burst discards remaining phases and history.
- **L=1:** degenerates to a registered direct-form FIR with a handshake.

## Timing
- Sample accepted in cycle c → branch 0 is loaded at the end of c+1 → `out_valid`/`out_phase=0` visible in cycle c+2.
- With `out_ready`=1, branch p is visible in cycle c+2+p, and branch L-1 in cycle c+L+1.
- `in_ready` is high in cycle c+L.
- With back-to-back input, throughput is one sample per L cycles and output is continuous (no bubble).
- `out_ready` low while `out_valid`=1:
  - out, out_phase and out_valid hold.
  - p does not advance.
  - in_ready=0 while busy.
- `in_valid` with in_ready=0: the sample is not taken; the source must hold it.
- No combinational path from `in` to `out`.

## Test plan
- **Impulse:** L=2, NUM_TAPS=4, h=[1,2,3,4], OUT_SHIFT=0. Stimulus: in=1, then 0, 0, out_ready=1. Response: out sequence 1,2,3,4,0,0 with out_phase 0,1,0,1,0,1. First out_valid 2 cycles after the accept.
- **Saturation:** DATA_WIDTH=5, all h=15, L=2, NUM_TAPS=4. Stimulus: in=15 held. Response: steady-state out=15 (acc=450). Stimulus: in=-16 held. Response: out=-16 (acc=-480).
- **Rounding:** OUT_SHIFT=2, h=[1,0,0,0], L=2. Stimulus and response: in=5→out 1; in=6→out 2; in=-6→out -1; in=-7→out -2.
- **Back-pressure:** hold out_ready=0 for 3 cycles during phase 0. Response: out/out_phase stable, in_ready=0. After release, the remaining phases follow in order with no sample lost or duplicated.
- **Continuous stream:** L=4, NUM_TAPS=8, in_valid always high. Response: one accept every 4 cycles, out_valid continuously high, output matches a golden polyphase model.
- **Mid-burst reset:** assert rst during phase 1. Response: out=0, out_valid=0 next cycle, in_ready=1. The next impulse reproduces the clean impulse response.
